// File: rtl/tm1638_responder.sv
// rtl/tm1638_responder.sv - TM1638 3-wire bus responder: command decode, display RAM, key-scan reply; optional error flags via TM1638_RESP_ERRCHK_EN
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_5MHz,
  input  logic        n_rst,
  input  logic        tm_stb,
  input  logic        tm_clk,
  input  logic        tm_dio_in,
  output logic        tm_dio_out,
  output logic        tm_dio_oe,
  input  logic [7:0]  keys,
  output logic [63:0] digits,
  output logic [7:0]  leds_green,
  output logic [7:0]  leds_red,
  output logic        display_on,
  output logic [2:0]  brightness,
  output logic        frame_done,
  output logic [2:0]  err
);

  // Position within a frame: waiting for the command byte, or what the command byte made of the rest
  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_READ,
    S_DISP,
    S_IGNORE
  } frame_t;

  frame_t state, state_next;

  logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
  logic       stb_q, clk_q;
  logic       stb_s, clk_s, dio_s;
  logic       stb_rise, clk_rise, clk_fall;
  logic       bit_rise, byte_done;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [7:0] rx_byte;

  logic       ram_we, load_addr, load_mode, load_disp, start_read;
  logic       fixed_mode;
  logic [3:0] addr;
  // Even bytes drive the digit segments; odd bytes only use SEG1/SEG2 for the LEDs,
  // so the upper six bits of odd bytes are not stored.
  logic [7:0][7:0] digit_ram;
  logic [7:0][1:0] led_ram;

  logic [31:0] reply_sr;
  logic [5:0]  reply_left;

  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dio_s    = dio_sync[SYNC_STAGES-1];
  assign stb_rise = stb_s & ~stb_q;
  assign clk_rise = clk_s & ~clk_q;
  assign clk_fall = ~clk_s & clk_q;
  assign bit_rise = clk_rise & ~stb_s;
  assign byte_done = bit_rise & (bit_cnt == 3'd7);
  assign rx_byte  = {dio_s, shift_reg};

  // Synchronise the bus pins; strobe and clock idle high, so they reset high to avoid false edges
  always_ff @(posedge clk_5MHz or posedge n_rst) begin
    if (n_rst) begin
      stb_sync <= '1;
      clk_sync <= '1;
      dio_sync <= '0;
      stb_q    <= 1'b1;
      clk_q    <= 1'b1;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], tm_stb};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], tm_clk};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], tm_dio_in};
      stb_q    <= stb_s;
      clk_q    <= clk_s;
    end
  end

  // LSB-first bit shifter; strobe high discards any partial byte
  always_ff @(posedge clk_5MHz or posedge n_rst) begin
    if (n_rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (stb_s) begin
      bit_cnt   <= '0;
    end else if (bit_rise) begin
      shift_reg <= rx_byte[7:1];
      bit_cnt   <= bit_cnt + 3'd1;
    end
  end

  // Frame state register
  always_ff @(posedge clk_5MHz or posedge n_rst) begin
    if (n_rst) state <= S_CMD;
    else       state <= state_next;
  end

  // Command decode on the first byte; later bytes handled by the frame kind
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    load_addr  = 1'b0;
    load_mode  = 1'b0;
    load_disp  = 1'b0;
    start_read = 1'b0;
    if (stb_s) begin
      state_next = S_CMD;
    end else if (byte_done) begin
      case (state)
        S_CMD: begin
          case (rx_byte[7:6])
            2'b01: begin
              load_mode = 1'b1;
              if (rx_byte[1]) begin
                start_read = 1'b1;
                state_next = S_READ;
              end else begin
                state_next = S_DATA;
              end
            end
            2'b11: begin
              load_addr  = 1'b1;
              state_next = S_ADDR;
            end
            2'b10: begin
              load_disp  = 1'b1;
              state_next = S_DISP;
            end
            default: state_next = S_IGNORE;
          endcase
        end
        S_ADDR:  ram_we = 1'b1;
        default: ;
      endcase
    end
  end

  // Address pointer, addressing mode, display RAM and display control
  always_ff @(posedge clk_5MHz or posedge n_rst) begin
    if (n_rst) begin
      fixed_mode <= 1'b0;
      addr       <= '0;
      digit_ram  <= '0;
      led_ram    <= '0;
      display_on <= 1'b0;
      brightness <= '0;
    end else begin
      if (load_mode) fixed_mode <= rx_byte[2];
      if (load_addr) begin
        addr <= rx_byte[3:0];
      end else if (ram_we) begin
        if (addr[0]) led_ram[addr[3:1]]   <= rx_byte[1:0];
        else         digit_ram[addr[3:1]] <= rx_byte;
        if (!fixed_mode) addr <= addr + 4'd1;
      end
      if (load_disp) begin
        display_on <= rx_byte[3];
        brightness <= rx_byte[2:0];
      end
    end
  end

  // Frame completion pulse: only frames that carried at least one whole byte
  always_ff @(posedge clk_5MHz or posedge n_rst) begin
    if (n_rst) frame_done <= 1'b0;
    else       frame_done <= stb_rise && (state != S_CMD);
  end

  // Key-scan reply: latched at read command, one bit per host clock fall, released after the last rise
  always_ff @(posedge clk_5MHz or posedge n_rst) begin
    if (n_rst) begin
      reply_sr   <= '0;
      reply_left <= '0;
      tm_dio_out <= 1'b0;
      tm_dio_oe  <= 1'b0;
    end else if (stb_s) begin
      reply_left <= '0;
      tm_dio_oe  <= 1'b0;
    end else if (start_read) begin
      reply_sr   <= {3'b0, keys[0], 3'b0, keys[4],
                     3'b0, keys[1], 3'b0, keys[5],
                     3'b0, keys[2], 3'b0, keys[6],
                     3'b0, keys[3], 3'b0, keys[7]};
      reply_left <= 6'd32;
    end else if (clk_fall && (reply_left != '0)) begin
      tm_dio_out <= reply_sr[0];
      tm_dio_oe  <= 1'b1;
      reply_sr   <= {1'b0, reply_sr[31:1]};
      reply_left <= reply_left - 6'd1;
    end else if (clk_rise && (reply_left == '0)) begin
      tm_dio_oe  <= 1'b0;
    end
  end

  // Digit and LED outputs are direct views of the display RAM (k=0 is the leftmost position)
  always_comb begin
    digits     = digit_ram;
    leds_green = '0;
    leds_red   = '0;
    for (int k = 0; k < 8; k++) begin
      leds_green[7-k] = led_ram[k][0];
      leds_red[7-k]   = led_ram[k][1];
    end
  end

`ifdef TM1638_RESP_ERRCHK_EN
  logic [2:0] err_q;
  logic       partial_byte, bad_sequence, unknown_cmd;

  assign partial_byte = stb_rise && (bit_cnt != 3'd0);
  assign bad_sequence = byte_done && ((state == S_DATA) || (state == S_DISP));
  assign unknown_cmd  = byte_done && (state == S_CMD) && (rx_byte[7:6] == 2'b00);

  // Sticky protocol error flags
  always_ff @(posedge clk_5MHz or posedge n_rst) begin
    if (n_rst) err_q <= '0;
    else       err_q <= err_q | {partial_byte, bad_sequence, unknown_cmd};
  end

  assign err = err_q;
`else
  assign err = 3'b000;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// tb/tb_tm1638_responder.sv - randomized self-checking bench for tm1638_responder against a byte-level bus model
module tb_tm1638_responder;
  localparam int PH     = 8;
  localparam int SETTLE = 5;
  localparam int K_CMD = 0, K_ADDR = 1, K_DATA = 2, K_READ = 3, K_DISP = 4, K_IGN = 5;

  logic        clk_5MHz = 1'b0;
  logic        n_rst = 1'b1;
  logic        tm_stb = 1'b1;
  logic        tm_clk = 1'b1;
  logic        tm_dio_in = 1'b0;
  logic [7:0]  keys = 8'h00;
  logic        tm_dio_out, tm_dio_oe, display_on, frame_done;
  logic [63:0] digits;
  logic [7:0]  leds_green, leds_red;
  logic [2:0]  brightness, err;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk_5MHz(clk_5MHz), .n_rst(n_rst), .tm_stb(tm_stb), .tm_clk(tm_clk),
    .tm_dio_in(tm_dio_in), .tm_dio_out(tm_dio_out), .tm_dio_oe(tm_dio_oe),
    .keys(keys), .digits(digits), .leds_green(leds_green), .leds_red(leds_red),
    .display_on(display_on), .brightness(brightness), .frame_done(frame_done), .err(err)
  );

  always #100 clk_5MHz = ~clk_5MHz;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_change = 0;
  int fd_cnt = 0;

  always @(posedge clk_5MHz) cyc <= cyc + 1;

  // Model state (byte-level view of the device)
  logic [7:0] m_ram [16];
  logic       m_fixed, m_on, m_oe, m_out;
  logic [3:0] m_addr;
  logic [2:0] m_bright, m_err;
  logic [7:0] m_sh;
  int         m_bits, m_kind, m_frames;
  logic       m_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_fixed = 0; m_on = 0; m_oe = 0; m_out = 0; m_addr = 0; m_bright = 0; m_err = 0;
    m_sh = 0; m_bits = 0; m_kind = K_CMD; m_frames = 0;
    m_q.delete();
  endtask

  task automatic m_apply(input logic [7:0] b);
    logic [7:0] rb;
    if (m_bits == 8) begin
      case (b[7:6])
        2'b01: begin
          m_fixed = b[2];
          if (b[1]) begin
            m_kind = K_READ;
            m_q.delete();
            for (int i = 0; i < 4; i++) begin
              rb = 8'h00;
              rb[0] = keys[7-i];
              rb[4] = keys[3-i];
              for (int j = 0; j < 8; j++) m_q.push_back(rb[j]);
            end
          end else m_kind = K_DATA;
        end
        2'b11: begin m_addr = b[3:0]; m_kind = K_ADDR; end
        2'b10: begin m_on = b[3]; m_bright = b[2:0]; m_kind = K_DISP; end
        default: begin m_err[0] = 1'b1; m_kind = K_IGN; end
      endcase
    end else begin
      if (m_kind == K_ADDR) begin
        m_ram[m_addr] = b;
        if (!m_fixed) m_addr = m_addr + 4'd1;
      end else if (m_kind == K_DATA || m_kind == K_DISP) begin
        m_err[1] = 1'b1;
      end
    end
  endtask

  function automatic logic [63:0] exp_digits();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = m_ram[2*k];
    return v;
  endfunction

  function automatic logic [7:0] exp_leds(input int seg);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[7-k] = m_ram[2*k+1][seg];
    return v;
  endfunction

  function automatic logic [2:0] exp_err();
`ifdef TM1638_RESP_ERRCHK_EN
    return m_err;
`else
    return 3'b000;
`endif
  endfunction

  // Frame-completion pulse counter
  always @(negedge clk_5MHz) begin
    if (n_rst) fd_cnt = 0;
    else if (frame_done) fd_cnt = fd_cnt + 1;
  end

  // Compare DUT against the model once the last pin change has propagated
  always @(negedge clk_5MHz) begin
    if (!n_rst && (cyc - t_change >= SETTLE)) begin
      check("digits", digits, exp_digits());
      check("leds_green", {56'd0, leds_green}, {56'd0, exp_leds(0)});
      check("leds_red", {56'd0, leds_red}, {56'd0, exp_leds(1)});
      check("display_on", {63'd0, display_on}, {63'd0, m_on});
      check("brightness", {61'd0, brightness}, {61'd0, m_bright});
      check("frames", fd_cnt, m_frames);
      check("dio_oe", {63'd0, tm_dio_oe}, {63'd0, m_oe});
      if (m_oe) check("dio_out", {63'd0, tm_dio_out}, {63'd0, m_out});
      check("err", {61'd0, err}, {61'd0, exp_err()});
    end
  end

  // Host-side bus driver
  task automatic wait_ph();
    repeat (PH) @(posedge clk_5MHz);
    #1;
  endtask

  task automatic frame_start();
    wait_ph();
    tm_stb = 1'b0; t_change = cyc;
    m_bits = 0; m_kind = K_CMD; m_q.delete();
  endtask

  task automatic frame_end();
    wait_ph();
    tm_stb = 1'b1; t_change = cyc;
    if (m_bits % 8 != 0) m_err[2] = 1'b1;
    if (m_bits >= 8) m_frames++;
    m_q.delete(); m_oe = 0;
  endtask

  task automatic clock_bit(input logic d, output logic rd);
    wait_ph();
    tm_clk = 1'b0; tm_dio_in = d; t_change = cyc;
    if (m_q.size() > 0) begin m_out = m_q.pop_front(); m_oe = 1; end
    wait_ph();
    rd = tm_dio_out;
    tm_clk = 1'b1; t_change = cyc;
    m_bits++;
    m_sh = {d, m_sh[7:1]};
    if (m_bits % 8 == 0) m_apply(m_sh);
    if (m_q.size() == 0) m_oe = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rd;
    for (int j = 0; j < 8; j++) clock_bit(b[j], rd);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic rd;
    for (int j = 0; j < 8; j++) begin
      clock_bit(1'b1, rd);
      v[j] = rd;
    end
  endtask

  task automatic one_byte_frame(input logic [7:0] b);
    frame_start(); send_byte(b); frame_end();
  endtask

  logic [7:0] rb0, rb1, rb2, rb3, cmd;
  logic       rdb;
  int         kind, nb;

  initial begin
    m_reset();
    repeat (5) @(posedge clk_5MHz);
    #1;
    check("rst_oe", {63'd0, tm_dio_oe}, 64'd0);
    check("rst_digits", digits, 64'd0);
    check("rst_leds", {48'd0, leds_green, leds_red}, 64'd0);
    check("rst_disp", {60'd0, display_on, brightness}, 64'd0);
    check("rst_err_fd", {60'd0, err, frame_done}, 64'd0);
    n_rst = 1'b0; t_change = cyc;

    // Auto-increment fill of all 16 bytes
    one_byte_frame(8'h40);
    frame_start(); send_byte(8'hC0);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    frame_end(); wait_ph();
    check("t1_digit0", {56'd0, digits[7:0]}, 64'h01);
    check("t1_green7", {63'd0, leds_green[7]}, 64'd0);
    check("t1_red7", {63'd0, leds_red[7]}, 64'd1);
    check("t1_frames", fd_cnt, 2);

    // Fixed address writes
    one_byte_frame(8'h44);
    frame_start(); send_byte(8'hC5); send_byte(8'hAA); send_byte(8'h55); frame_end(); wait_ph();
    check("t2_green5", {63'd0, leds_green[5]}, 64'd1);
    check("t2_red5", {63'd0, leds_red[5]}, 64'd0);
    check("t2_ram6", {56'd0, digits[31:24]}, 64'h07);

    // Display control
    one_byte_frame(8'h8F); wait_ph();
    check("t3_on", {60'd0, display_on, brightness}, 64'hF);
    one_byte_frame(8'h80); wait_ph();
    check("t3_off", {60'd0, display_on, brightness}, 64'h0);

    // Key read
    keys = 8'b1000_0001;
    frame_start(); send_byte(8'h42);
    read_byte(rb0); read_byte(rb1); read_byte(rb2); read_byte(rb3);
    wait_ph();
    check("t4_reply", {32'd0, rb3, rb2, rb1, rb0}, 64'h10000001);
    check("t4_oe_after", {63'd0, tm_dio_oe}, 64'd0);
    frame_end();

    // Address wrap 15 -> 0
    one_byte_frame(8'h40);
    frame_start(); send_byte(8'hCF); send_byte(8'h11); send_byte(8'h22); frame_end(); wait_ph();
    check("t5_green0", {56'd0, leds_green[0], leds_red[0]}, 64'h2);
    check("t5_ram0", {56'd0, digits[7:0]}, 64'h22);

    // Aborted byte
    frame_start();
    for (int j = 0; j < 5; j++) clock_bit(j < 2, rdb);
    frame_end(); wait_ph();
    check("t6_frames", fd_cnt, 9);
    check("t6_ram0", {56'd0, digits[7:0]}, 64'h22);
`ifdef TM1638_RESP_ERRCHK_EN
    check("t6_err", {61'd0, err}, 64'h4);
`else
    check("t6_err", {61'd0, err}, 64'h0);
`endif

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      keys = 8'($urandom);
      kind = $urandom_range(0, 5);
      case (kind)
        0: cmd = 8'h40 | 8'($urandom_range(0, 1) << 2);
        1: cmd = 8'h42 | 8'($urandom_range(0, 1) << 2);
        2: cmd = 8'hC0 | 8'($urandom_range(0, 15));
        3: cmd = 8'h80 | 8'($urandom_range(0, 15));
        default: cmd = 8'($urandom);
      endcase
      nb = (kind == 1) ? 4 : $urandom_range(0, 4);
      frame_start();
      send_byte(cmd);
      for (int i = 0; i < nb; i++) send_byte(8'($urandom));
      if ($urandom_range(0, 4) == 0)
        for (int j = $urandom_range(1, 7); j > 0; j--) clock_bit(1'($urandom), rdb);
      frame_end();
    end

    // Reset in the middle of a key reply
    one_byte_frame(8'h8A);
    frame_start(); send_byte(8'h42);
    for (int j = 0; j < 12; j++) clock_bit(1'b1, rdb);
    check("t7_oe_before", {63'd0, tm_dio_oe}, 64'd1);
    #20 n_rst = 1'b1;
    #1;
    check("t7_oe", {63'd0, tm_dio_oe}, 64'd0);
    check("t7_digits", digits, 64'd0);
    check("t7_leds", {48'd0, leds_green, leds_red}, 64'd0);
    check("t7_disp", {60'd0, display_on, brightness}, 64'd0);
    tm_stb = 1'b1; tm_clk = 1'b1;
    m_reset();
    repeat (3) @(posedge clk_5MHz);
    #1;
    n_rst = 1'b0; t_change = cyc;
    wait_ph(); wait_ph();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
